// File: rtl/complex_alu_pkg.sv
// ---------------------------------------------------------------------------
// complex_alu_pkg
// Shared definitions for the complex-ALU operand interface:
//   - op_e        : operation encodings driven on `operation`
//   - tx_state_e  : transmitter state machine states
//   - max_int / clog2_min1 : helpers used to size counters and address buses
//   - op_legal    : shape check of an operation against the matrix dimensions
// ---------------------------------------------------------------------------
package complex_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_ILL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        REJECT,
        START,
        STREAM,
        WAIT,
        DONE
    } tx_state_e;

    localparam int OP_W = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Never returns 0 so that degenerate 1-element matrices still get a
    // 1-bit bus instead of a zero-width one.
    function automatic int clog2_min1(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

    // Element-wise ops need identical shapes; multiply needs inner
    // dimensions to agree; the reserved encoding is never accepted.
    function automatic logic op_legal(input logic [OP_W-1:0] op,
                                      input int ar, input int ac,
                                      input int br, input int bc);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_ADD, OP_SUB: ok = (ar == br) && (ac == bc);
            OP_MUL:         ok = (ac == br);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/complex_matrix_regfile.sv
// ---------------------------------------------------------------------------
// complex_matrix_regfile
// Row-major storage for one operand matrix of rows*columns elements.
// Ports:
//   clk, rst   : clock, synchronous active-high clear of every element
//   wr_en      : write strobe (already qualified by the caller)
//   wr_addr    : element index; indices beyond the matrix are dropped
//   wr_data    : element value
//   rd_idx     : combinational read index; out-of-range reads return 0
//   rd_data    : element at rd_idx
// ---------------------------------------------------------------------------
module complex_matrix_regfile
    import complex_alu_pkg::*;
#(
    parameter int rows    = 3,
    parameter int columns = 3,
    parameter int size    = 16,
    parameter int aw      = 4,
    parameter int iw      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [aw-1:0]   wr_addr,
    input  logic [size-1:0] wr_data,
    input  logic [iw-1:0]   rd_idx,
    output logic [size-1:0] rd_data
);

    localparam int unsigned N  = rows * columns;
    localparam int          LW = clog2_min1(N);

    logic [size-1:0] mem_q [N];
    logic [size-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (wr_en && (32'(wr_addr) < N)) begin
            mem_d[LW'(wr_addr)] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // The stream walks past the end of the smaller matrix; those beats
    // must carry zero rather than an aliased element.
    assign rd_data = (32'(rd_idx) < N) ? mem_q[LW'(rd_idx)] : '0;

endmodule

// File: rtl/complex_matrix_tx.sv
// ---------------------------------------------------------------------------
// complex_matrix_tx
// Transmitter side of the complex-ALU operand interface. A host loads
// matrices A and B, pulses `go`, and this block issues `start`, streams both
// matrices row-major, then waits for the ALU's verdict and reports it.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   wr_en/wr_sel/wr_addr/wr_data : host write port (A when wr_sel=0, B when 1)
//   go, op_in               : start request and requested operation
//   busy, done, err         : status (done is a pulse, err valid with done)
//   result_q                : ALU result captured on successful completion
//   start, operation        : command to the ALU
//   m1/a_valid, m2/b_valid  : A and B element streams
//   alu_valid/alu_error/alu_result : ALU response
// ---------------------------------------------------------------------------
module complex_matrix_tx
    import complex_alu_pkg::*;
#(
    parameter int a_row    = 3,
    parameter int a_column = 3,
    parameter int b_row    = 3,
    parameter int b_column = 3,
    parameter int size     = 16,
    parameter int timeout  = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [clog2_min1(max_int(a_row*a_column, b_row*b_column))-1:0] wr_addr,
    input  logic [size-1:0]     wr_data,
    input  logic                go,
    input  logic [1:0]          op_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [3*size-1:0]   result_q,
    output logic                start,
    output logic [1:0]          operation,
    output logic [size-1:0]     m1,
    output logic [size-1:0]     m2,
    output logic                a_valid,
    output logic                b_valid,
    input  logic                alu_valid,
    input  logic                alu_error,
    input  logic [3*size-1:0]   alu_result
);

    localparam int unsigned NA   = a_row * a_column;
    localparam int unsigned NB   = b_row * b_column;
    localparam int unsigned NMAX = max_int(NA, NB);
    localparam int          AW   = clog2_min1(NMAX);
    localparam int          BW   = clog2_min1(NMAX + 1);
    localparam int          WW   = clog2_min1(timeout + 1);

    tx_state_e         state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [3*size-1:0] result_d;
    logic              start_q, start_d;
    logic [1:0]        operation_q, operation_d;
    logic [size-1:0]   m1_q, m1_d, m2_q, m2_d;
    logic              a_valid_q, a_valid_d, b_valid_q, b_valid_d;

    logic              idle;
    logic              op_ok;
    logic              last_beat;
    logic [BW-1:0]     rd_idx;
    logic [size-1:0]   a_rd, b_rd;
    logic              a_in_range, b_in_range;

    assign idle      = (state_q == IDLE);
    assign op_ok     = op_legal(op_in, a_row, a_column, b_row, b_column);
    assign last_beat = (32'(beat_q) == NMAX - 1);

    // Outputs are registered, so the element read now is the one shown on
    // the next beat: A[0] when leaving START, A[k+1] while on beat k.
    assign rd_idx     = (state_q == START) ? '0 : beat_q + BW'(1);
    assign a_in_range = (32'(rd_idx) < NA);
    assign b_in_range = (32'(rd_idx) < NB);

    complex_matrix_regfile #(
        .rows(a_row), .columns(a_column), .size(size), .aw(AW), .iw(BW)
    ) u_regfile_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en && !wr_sel && idle),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (a_rd)
    );

    complex_matrix_regfile #(
        .rows(b_row), .columns(b_column), .size(size), .aw(AW), .iw(BW)
    ) u_regfile_b (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en && wr_sel && idle),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (b_rd)
    );

    // Next-state and next-output logic. Every output is computed here for
    // the cycle after the transition, so all ports come straight from flops.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        err_d       = err_q;
        result_d    = result_q;
        start_d     = 1'b0;
        operation_d = operation_q;
        m1_d        = '0;
        m2_d        = '0;
        a_valid_d   = 1'b0;
        b_valid_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (go) begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    if (op_ok) begin
                        state_d     = START;
                        start_d     = 1'b1;
                        operation_d = op_in;
                    end else begin
                        state_d = REJECT;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            REJECT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            START: begin
                state_d   = STREAM;
                beat_d    = '0;
                a_valid_d = a_in_range;
                b_valid_d = b_in_range;
                m1_d      = a_in_range ? a_rd : '0;
                m2_d      = b_in_range ? b_rd : '0;
            end
            STREAM: begin
                if (last_beat) begin
                    state_d = WAIT;
                    wait_d  = '0;
                end else begin
                    beat_d    = rd_idx;
                    a_valid_d = a_in_range;
                    b_valid_d = b_in_range;
                    m1_d      = a_in_range ? a_rd : '0;
                    m2_d      = b_in_range ? b_rd : '0;
                end
            end
            WAIT: begin
                // An error report takes priority over a simultaneous result.
                if (alu_error) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (alu_valid) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    err_d    = 1'b0;
                    result_d = alu_result;
                end else if (32'(wait_q) == timeout) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            DONE: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                operation_d = '0;
                beat_d      = '0;
                wait_d      = '0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wait_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            start_q     <= 1'b0;
            operation_q <= '0;
            m1_q        <= '0;
            m2_q        <= '0;
            a_valid_q   <= 1'b0;
            b_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
            start_q     <= start_d;
            operation_q <= operation_d;
            m1_q        <= m1_d;
            m2_q        <= m2_d;
            a_valid_q   <= a_valid_d;
            b_valid_q   <= b_valid_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign start     = start_q;
    assign operation = operation_q;
    assign m1        = m1_q;
    assign m2        = m2_q;
    assign a_valid   = a_valid_q;
    assign b_valid   = b_valid_q;

endmodule

// File: tb/tb_complex_matrix_tx.sv
// ---------------------------------------------------------------------------
// tb_complex_matrix_tx
// Directed bench for complex_matrix_tx with the default 3x3 / 16-bit /
// timeout=1023 configuration. Inputs change 1 time unit after each rising
// edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_complex_matrix_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, wr_sel;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        go;
    logic [1:0]  op_in;
    logic        busy, done, err;
    logic [47:0] result_q;
    logic        start;
    logic [1:0]  operation;
    logic [15:0] m1, m2;
    logic        a_valid, b_valid;
    logic        alu_valid, alu_error;
    logic [47:0] alu_result;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] a_vals [9] = '{16'h0402, 16'h0301, 16'h0402, 16'h0103, 16'h0202,
                                16'h0706, 16'h0207, 16'h0702, 16'h0100};
    logic [15:0] b_vals [9] = '{16'h1011, 16'h1213, 16'h1415, 16'h1617, 16'h1819,
                                16'h1A1B, 16'h1C1D, 16'h1E1F, 16'h2021};

    localparam logic [47:0] RES1 = 48'h000808000509;
    localparam logic [47:0] RES2 = 48'h123456789ABC;

    always #5 clk = ~clk;

    complex_matrix_tx dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .go         (go),
        .op_in      (op_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result_q   (result_q),
        .start      (start),
        .operation  (operation),
        .m1         (m1),
        .m2         (m2),
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .alu_valid  (alu_valid),
        .alu_error  (alu_error),
        .alu_result (alu_result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleFor(input int n);
        repeat (n) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Drives the host port for exactly one cycle, then returns it to idle.
    task automatic applyStimulus(input logic we, input logic sel, input logic [3:0] addr,
                                 input logic [15:0] data, input logic g, input logic [1:0] op);
        wr_en   = we;
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = data;
        go      = g;
        op_in   = op;
        tick();
        wr_en   = 1'b0;
        go      = 1'b0;
    endtask

    task automatic checkAllZero(input string ctx);
        checkFlag({ctx, " busy"}, busy, 1'b0);
        checkFlag({ctx, " done"}, done, 1'b0);
        checkFlag({ctx, " err"}, err, 1'b0);
        checkFlag({ctx, " start"}, start, 1'b0);
        checkFlag({ctx, " a_valid"}, a_valid, 1'b0);
        checkFlag({ctx, " b_valid"}, b_valid, 1'b0);
        checkOutput({ctx, " operation"}, 64'(operation), 64'd0);
        checkOutput({ctx, " m1"}, 64'(m1), 64'd0);
        checkOutput({ctx, " m2"}, 64'(m2), 64'd0);
        checkOutput({ctx, " result_q"}, 64'(result_q), 64'd0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        go = 1'b0; op_in = '0; alu_valid = 1'b0; alu_error = 1'b0; alu_result = '0;
        idleFor(2);
        checkAllZero("reset");
        rst = 1'b0;
        tick();

        // Load A, then B; the last B write coincides with go (op add).
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 4'(i), a_vals[i], 1'b0, 2'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 4'(i), b_vals[i], 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b1, 4'd8, b_vals[8], 1'b1, 2'd0);
        checkFlag("add start", start, 1'b1);
        checkOutput("add operation", 64'(operation), 64'd0);
        checkFlag("add busy", busy, 1'b1);
        checkFlag("add a_valid in START", a_valid, 1'b0);
        for (int k = 0; k < 9; k++) begin
            tick();
            checkOutput($sformatf("add m1 beat %0d", k), 64'(m1), 64'(a_vals[k]));
            checkOutput($sformatf("add m2 beat %0d", k), 64'(m2), 64'(b_vals[k]));
            checkFlag($sformatf("add a_valid beat %0d", k), a_valid, 1'b1);
            checkFlag($sformatf("add b_valid beat %0d", k), b_valid, 1'b1);
            checkFlag($sformatf("add start beat %0d", k), start, 1'b0);
        end
        tick();
        checkFlag("wait a_valid", a_valid, 1'b0);
        checkOutput("wait m1", 64'(m1), 64'd0);
        idleFor(3);
        checkFlag("add done before response", done, 1'b0);
        alu_valid = 1'b1; alu_result = RES1;
        tick();
        alu_valid = 1'b0;
        checkFlag("add done", done, 1'b1);
        checkFlag("add err", err, 1'b0);
        checkOutput("add result_q", 64'(result_q), 64'(RES1));
        tick();
        checkFlag("add done pulse ends", done, 1'b0);
        checkFlag("add busy drops", busy, 1'b0);

        // Illegal op is rejected one cycle later with no ALU activity.
        applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 2'd3);
        checkFlag("ill done", done, 1'b1);
        checkFlag("ill err", err, 1'b1);
        checkFlag("ill start", start, 1'b0);
        checkFlag("ill a_valid", a_valid, 1'b0);
        tick();
        checkFlag("ill done pulse ends", done, 1'b0);
        checkFlag("ill err holds", err, 1'b1);
        checkFlag("ill busy", busy, 1'b0);
        checkFlag("ill start after", start, 1'b0);

        // Multiply with a silent ALU: WAIT entered at N+11, abort at N+1035.
        applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 2'd2);
        checkFlag("mul start", start, 1'b1);
        checkOutput("mul operation", 64'(operation), 64'd2);
        checkFlag("mul err cleared by go", err, 1'b0);
        idleFor(1033);
        checkFlag("timeout done early", done, 1'b0);
        checkFlag("timeout busy", busy, 1'b1);
        tick();
        checkFlag("timeout done", done, 1'b1);
        checkFlag("timeout err", err, 1'b1);
        checkOutput("timeout result_q", 64'(result_q), 64'(RES1));
        tick();

        // Sub; ALU chatter during STREAM is ignored, then error+valid in WAIT.
        applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 2'd1);
        checkOutput("sub operation", 64'(operation), 64'd1);
        idleFor(2);
        alu_valid = 1'b1; alu_error = 1'b1;
        tick();
        alu_valid = 1'b0; alu_error = 1'b0;
        checkFlag("stream ignores alu done", done, 1'b0);
        checkOutput("stream ignores alu m1", 64'(m1), 64'(a_vals[2]));
        checkFlag("stream ignores alu a_valid", a_valid, 1'b1);
        idleFor(7);
        alu_valid = 1'b1; alu_error = 1'b1; alu_result = 48'hAAAABBBBCCCC;
        tick();
        alu_valid = 1'b0; alu_error = 1'b0;
        checkFlag("both done", done, 1'b1);
        checkFlag("both err", err, 1'b1);
        checkOutput("both result_q kept", 64'(result_q), 64'(RES1));
        tick();

        // Write and go while busy are both dropped.
        applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 2'd0);
        idleFor(2);
        applyStimulus(1'b1, 1'b0, 4'd0, 16'hDEAD, 1'b1, 2'd2);
        checkFlag("busy go no start", start, 1'b0);
        checkOutput("busy go operation", 64'(operation), 64'd0);
        checkOutput("busy m1 order", 64'(m1), 64'(a_vals[2]));
        idleFor(7);
        alu_valid = 1'b1; alu_result = RES2;
        tick();
        alu_valid = 1'b0;
        checkFlag("busy run done", done, 1'b1);
        checkOutput("busy run result_q", 64'(result_q), 64'(RES2));
        tick();

        // Reset at beat 4 aborts silently and clears both matrices.
        applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 2'd0);
        tick();
        checkOutput("A[0] unchanged by busy write", 64'(m1), 64'(a_vals[0]));
        idleFor(4);
        checkOutput("rst beat 4 m1", 64'(m1), 64'(a_vals[4]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkAllZero("mid-stream reset");
        tick();
        checkFlag("no done after reset", done, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 2'd0);
        checkFlag("post-reset start", start, 1'b1);
        tick();
        checkOutput("zero m1 beat 0", 64'(m1), 64'd0);
        checkOutput("zero m2 beat 0", 64'(m2), 64'd0);
        checkFlag("zero a_valid beat 0", a_valid, 1'b1);
        idleFor(8);
        checkOutput("zero m1 beat 8", 64'(m1), 64'd0);
        checkFlag("zero b_valid beat 8", b_valid, 1'b1);
        tick();
        alu_valid = 1'b1; alu_result = 48'h1;
        tick();
        alu_valid = 1'b0;
        checkFlag("zero run done", done, 1'b1);
        checkOutput("zero run result_q", 64'(result_q), 64'h1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
